// File: rtl/parking_system_pkg.sv
// Shared definitions for the car-park gate controller: state encodings and
// 7-segment glyphs (segments {g,f,e,d,c,b,a}, active-low).
package parking_system_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE          = 3'd0;
   localparam state_t WAIT_PASSWORD = 3'd1;
   localparam state_t WRONG_PASS    = 3'd2;
   localparam state_t RIGHT_PASS    = 3'd3;
   localparam state_t STOP          = 3'd4;

   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_N     = 7'b0101011;
   localparam logic [6:0] GLYPH_G     = 7'b0000010;
   localparam logic [6:0] GLYPH_O     = 7'b1000000;
   localparam logic [6:0] GLYPH_S     = 7'b0010010;
   localparam logic [6:0] GLYPH_P     = 7'b0001100;

   // Width of a counter that must hold 0..max_val without wrapping.
   function automatic int count_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/parking_hex_decoder.sv
// Combinational state-to-display decode for the two driver-facing 7-segment
// displays; unknown states show blank.
module parking_hex_decoder
   import parking_system_pkg::*;
(
   input  state_t     state,
   output logic [6:0] hex_1,
   output logic [6:0] hex_2
);

   always_comb begin
      hex_1 = GLYPH_BLANK;
      hex_2 = GLYPH_BLANK;
      case (state)
         WAIT_PASSWORD: begin
            hex_1 = GLYPH_E;
            hex_2 = GLYPH_N;
         end
         WRONG_PASS: begin
            hex_1 = GLYPH_E;
            hex_2 = GLYPH_E;
         end
         RIGHT_PASS: begin
            hex_1 = GLYPH_G;
            hex_2 = GLYPH_O;
         end
         STOP: begin
            hex_1 = GLYPH_S;
            hex_2 = GLYPH_P;
         end
         default: begin
            hex_1 = GLYPH_BLANK;
            hex_2 = GLYPH_BLANK;
         end
      endcase
   end

endmodule

// File: rtl/parking_system.sv
// Single-entrance car-park gate controller: arrival detection, fixed settling
// wait, two-digit password check, tailgate blocking, LED and display drive.
module parking_system
   import parking_system_pkg::*;
#(
   parameter int         WAIT_CYCLES = 4,
   parameter logic [1:0] PASS_1      = 2'b01,
   parameter logic [1:0] PASS_2      = 2'b10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sensor_entrance,
   input  logic       sensor_exit,
   input  logic [1:0] password_1,
   input  logic [1:0] password_2,
   output logic       GREEN_LED,
   output logic       RED_LED,
   output logic [6:0] HEX_1,
   output logic [6:0] HEX_2
);

   localparam int                CNT_W     = count_width(WAIT_CYCLES);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             green_q, green_d;
   logic             red_q, red_d;
   logic             pass_ok;

   assign pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);

   // Counter stops at WAIT_LAST and is zero outside WAIT_PASSWORD, so it never wraps.
   always_comb begin
      state_d = IDLE;
      cnt_d   = '0;
      case (state_q)
         IDLE: begin
            state_d = sensor_entrance ? WAIT_PASSWORD : IDLE;
         end
         WAIT_PASSWORD: begin
            if (cnt_q < WAIT_LAST) begin
               state_d = WAIT_PASSWORD;
               cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               state_d = pass_ok ? RIGHT_PASS : WRONG_PASS;
            end
         end
         WRONG_PASS: begin
            state_d = pass_ok ? RIGHT_PASS : WRONG_PASS;
         end
         RIGHT_PASS: begin
            if (sensor_entrance && sensor_exit) begin
               state_d = STOP;
            end else if (sensor_exit) begin
               state_d = IDLE;
            end else begin
               state_d = RIGHT_PASS;
            end
         end
         STOP: begin
            state_d = pass_ok ? RIGHT_PASS : STOP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // LEDs follow the state one edge late; blinking states invert the held value.
   always_comb begin
      green_d = 1'b0;
      red_d   = 1'b0;
      case (state_q)
         WAIT_PASSWORD: red_d   = 1'b1;
         WRONG_PASS:    red_d   = ~red_q;
         RIGHT_PASS:    green_d = ~green_q;
         STOP:          red_d   = ~red_q;
         default: begin
            green_d = 1'b0;
            red_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         green_q <= 1'b0;
         red_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         green_q <= green_d;
         red_q   <= red_d;
      end
   end

   assign GREEN_LED = green_q;
   assign RED_LED   = red_q;

   parking_hex_decoder u_hex (
      .state (state_q),
      .hex_1 (HEX_1),
      .hex_2 (HEX_2)
   );

endmodule

// File: tb/tb_parking_system.sv
// Scenario bench for parking_system: each task queues stimulus with the
// outputs expected after the following clock edge, then replays and checks.
module tb_parking_system;

   logic       clk;
   logic       reset_n;
   logic       se;
   logic       sx;
   logic [1:0] p1;
   logic [1:0] p2;
   logic       g;
   logic       r;
   logic [6:0] h1;
   logic [6:0] h2;

   localparam logic [6:0] H_BLANK = 7'b1111111;
   localparam logic [6:0] H_E     = 7'b0000110;
   localparam logic [6:0] H_N     = 7'b0101011;
   localparam logic [6:0] H_G     = 7'b0000010;
   localparam logic [6:0] H_O     = 7'b1000000;
   localparam logic [6:0] H_S     = 7'b0010010;
   localparam logic [6:0] H_P     = 7'b0001100;

   typedef struct {
      logic       se;
      logic       sx;
      logic [1:0] p1;
      logic [1:0] p2;
   } stim_t;

   typedef struct {
      string       name;
      logic [15:0] v;
   } exp_t;

   stim_t stim_q[$];
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;

   parking_system dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sensor_entrance (se),
      .sensor_exit     (sx),
      .password_1      (p1),
      .password_2      (p2),
      .GREEN_LED       (g),
      .RED_LED         (r),
      .HEX_1           (h1),
      .HEX_2           (h2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "time limit");
   end

   task automatic add(input logic se_i, input logic sx_i, input logic [1:0] p1_i,
                      input logic [1:0] p2_i, input string name, input logic ge,
                      input logic re, input logic [6:0] h1e, input logic [6:0] h2e);
      stim_t s;
      exp_t  e;
      s.se = se_i;
      s.sx = sx_i;
      s.p1 = p1_i;
      s.p2 = p2_i;
      stim_q.push_back(s);
      e.name = name;
      e.v    = {ge, re, h1e, h2e};
      sb.push_back(e);
   endtask

   task automatic test_reset();
      stim_t s;
      exp_t  e;
      reset_n = 1'b0;
      se = 1'b0;
      sx = 1'b0;
      p1 = 2'd0;
      p2 = 2'd0;
      #50;
      checks++;
      if ({g, r, h1, h2} !== {1'b0, 1'b0, H_BLANK, H_BLANK}) begin
         errors++;
         $display("FAIL reset_hold: got %b required %b", {g, r, h1, h2}, {1'b0, 1'b0, H_BLANK, H_BLANK});
      end
      #50;
      reset_n = 1'b1;
      add(0, 0, 0, 0, "idle_stay", 0, 0, H_BLANK, H_BLANK);
      add(0, 0, 0, 0, "idle_stay", 0, 0, H_BLANK, H_BLANK);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
   endtask

   task automatic test_wrong_pass();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, "wait_enter", 0, 0, H_E, H_N);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, "wait_hold", 0, 1, H_E, H_N);
      add(0, 0, 0, 0, "wrong_enter", 0, 1, H_E, H_E);
      add(0, 0, 0, 0, "wrong_blink", 0, 0, H_E, H_E);
      add(0, 1, 3, 3, "wrong_blink", 0, 1, H_E, H_E);
      add(0, 0, 0, 0, "wrong_blink", 0, 0, H_E, H_E);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
   endtask

   task automatic test_right_pass();
      stim_t s;
      exp_t  e;
      add(0, 0, 1, 2, "right_enter", 0, 1, H_G, H_O);
      add(0, 0, 1, 2, "right_blink", 1, 0, H_G, H_O);
      add(1, 0, 0, 0, "right_entr_only", 0, 0, H_G, H_O);
      add(0, 0, 0, 0, "right_blink", 1, 0, H_G, H_O);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
   endtask

   task automatic test_exit();
      stim_t s;
      exp_t  e;
      add(0, 1, 0, 0, "exit_to_idle", 0, 0, H_BLANK, H_BLANK);
      add(0, 0, 0, 0, "idle_after_exit", 0, 0, H_BLANK, H_BLANK);
      add(0, 0, 1, 2, "idle_ignores_pw", 0, 0, H_BLANK, H_BLANK);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
   endtask

   task automatic test_tailgate();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, "tg_wait_enter", 0, 0, H_E, H_N);
      add(0, 0, 0, 0, "tg_wait_hold", 0, 1, H_E, H_N);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 2, "tg_wait_no_early_exit", 0, 1, H_E, H_N);
      add(0, 0, 1, 2, "tg_last_cycle_pass", 0, 1, H_G, H_O);
      add(0, 0, 0, 0, "tg_right_blink", 1, 0, H_G, H_O);
      add(1, 1, 0, 0, "tg_stop_enter", 0, 0, H_S, H_P);
      add(0, 0, 0, 0, "tg_stop_blink", 0, 1, H_S, H_P);
      add(0, 1, 0, 0, "tg_stop_blink", 0, 0, H_S, H_P);
      add(0, 0, 1, 2, "tg_stop_to_right", 0, 1, H_G, H_O);
      add(0, 0, 0, 0, "tg_right_blink", 1, 0, H_G, H_O);
      add(0, 1, 0, 0, "tg_exit_to_idle", 0, 0, H_BLANK, H_BLANK);
      add(0, 0, 0, 0, "tg_idle", 0, 0, H_BLANK, H_BLANK);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
   endtask

   task automatic test_async_reset();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, "ar_wait_enter", 0, 0, H_E, H_N);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, "ar_wait_hold", 0, 1, H_E, H_N);
      add(0, 0, 0, 0, "ar_wrong_enter", 0, 1, H_E, H_E);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({g, r, h1, h2} !== {1'b0, 1'b0, H_BLANK, H_BLANK}) begin
         errors++;
         $display("FAIL ar_immediate: got %b required %b", {g, r, h1, h2}, {1'b0, 1'b0, H_BLANK, H_BLANK});
      end
      se = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({g, r, h1, h2} !== {1'b0, 1'b0, H_BLANK, H_BLANK}) begin
         errors++;
         $display("FAIL ar_held: got %b required %b", {g, r, h1, h2}, {1'b0, 1'b0, H_BLANK, H_BLANK});
      end
      @(negedge clk);
      reset_n = 1'b1;
      add(0, 0, 0, 0, "ar_idle_after", 0, 0, H_BLANK, H_BLANK);
      add(1, 0, 0, 0, "ar_wait_again", 0, 0, H_E, H_N);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, "ar_wait_again_hold", 0, 1, H_E, H_N);
      add(0, 0, 0, 0, "ar_wrong_again", 0, 1, H_E, H_E);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         se = s.se; sx = s.sx; p1 = s.p1; p2 = s.p2;
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({g, r, h1, h2} !== e.v) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, {g, r, h1, h2}, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrong_pass();
      test_right_pass();
      test_exit();
      test_tailgate();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
